// File: rtl/serializer_rr_scheduler.sv
// Round-robin front end for a shared 8-byte serializer: arbitrates four requesters,
// loads the winner's payload onto the byte lanes, forwards returned beats tagged with the owner ID.
module serializer_rr_scheduler #(
  parameter int BEATS   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [255:0] req_data,
  output logic [3:0]   ack,
  output logic [3:0]   done,
  output logic [7:0]   a_0,
  output logic [7:0]   a_1,
  output logic [7:0]   a_2,
  output logic [7:0]   a_3,
  output logic [7:0]   a_4,
  output logic [7:0]   a_5,
  output logic [7:0]   a_6,
  output logic [7:0]   a_7,
  output logic         begin_wr,
  input  logic [7:0]   dout,
  input  logic         outen,
  output logic [7:0]   out_data,
  output logic         out_valid,
  output logic [1:0]   out_id,
  output logic         timeout_err,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, START, STREAM, DONE} state_t;

  state_t     state_q, state_d;
  logic [1:0] last_grant, grant_id;
  logic [1:0] winner, scan_idx;
  logic       found;
  logic [3:0] beat_cnt;
  logic [7:0] wdog;
  logic       aborted;
  logic       beat_last, wd_last;
  logic [7:0] a_q [8];

  assign a_0 = a_q[0];
  assign a_1 = a_q[1];
  assign a_2 = a_q[2];
  assign a_3 = a_q[3];
  assign a_4 = a_q[4];
  assign a_5 = a_q[5];
  assign a_6 = a_q[6];
  assign a_7 = a_q[7];

  assign beat_last = (beat_cnt + 4'd1) == 4'(BEATS);
  assign wd_last   = (wdog + 8'd1) == 8'(TIMEOUT);

  // Scan upward from the requester after the last one served; offset 4 wraps back to it.
  always_comb begin
    winner   = last_grant;
    scan_idx = last_grant;
    found    = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      scan_idx = last_grant + 2'(i);
      if (!found && req[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (found) state_d = START;
      START:  state_d = STREAM;
      STREAM: begin
        // A beat on the watchdog's final cycle still counts; the abort path only fires without outen.
        if (outen && beat_last)    state_d = DONE;
        else if (!outen && wd_last) state_d = DONE;
      end
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant  <= 2'd3;
      grant_id    <= 2'd0;
      ack         <= 4'd0;
      done        <= 4'd0;
      begin_wr    <= 1'b0;
      out_data    <= 8'd0;
      out_valid   <= 1'b0;
      out_id      <= 2'd0;
      timeout_err <= 1'b0;
      beat_cnt    <= 4'd0;
      wdog        <= 8'd0;
      aborted     <= 1'b0;
      for (int k = 0; k < 8; k++) a_q[k] <= 8'd0;
    end else begin
      ack         <= 4'd0;
      done        <= 4'd0;
      begin_wr    <= 1'b0;
      out_valid   <= 1'b0;
      timeout_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found) begin
            for (int k = 0; k < 8; k++) a_q[k] <= req_data[{winner, 3'(k), 3'b000} +: 8];
            grant_id <= winner;
            ack      <= 4'b0001 << winner;
          end
        end
        START: begin
          begin_wr <= 1'b1;
          beat_cnt <= 4'd0;
          wdog     <= 8'd0;
          aborted  <= 1'b0;
        end
        STREAM: begin
          if (outen) begin
            out_data  <= dout;
            out_valid <= 1'b1;
            out_id    <= grant_id;
            beat_cnt  <= beat_cnt + 4'd1;
            wdog      <= 8'd0;
          end else begin
            wdog <= wdog + 8'd1;
            if (wd_last) aborted <= 1'b1;
          end
        end
        DONE: begin
          done        <= 4'b0001 << grant_id;
          timeout_err <= aborted;
          last_grant  <= grant_id;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serializer_rr_scheduler.sv
// Bench for serializer_rr_scheduler: arbitration table, hand-written corner sequences and
// randomized bursts checked against a transaction-level round-robin model.
module tb_serializer_rr_scheduler;
  localparam int BEATS   = 8;
  localparam int TIMEOUT = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [255:0] req_data;
  logic [3:0]   ack, done;
  logic [7:0]   a_arr [8];
  logic         begin_wr;
  logic [7:0]   dout;
  logic         outen;
  logic [7:0]   out_data;
  logic         out_valid;
  logic [1:0]   out_id;
  logic         timeout_err;
  logic         busy;

  serializer_rr_scheduler #(.BEATS(BEATS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .ack(ack), .done(done),
    .a_0(a_arr[0]), .a_1(a_arr[1]), .a_2(a_arr[2]), .a_3(a_arr[3]),
    .a_4(a_arr[4]), .a_5(a_arr[5]), .a_6(a_arr[6]), .a_7(a_arr[7]),
    .begin_wr(begin_wr), .dout(dout), .outen(outen),
    .out_data(out_data), .out_valid(out_valid), .out_id(out_id),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          stray_to = 0;
  logic [9:0]  beat_q [$];
  int          gaps [BEATS];
  logic [1:0]  model_last;

  always @(posedge clk) cyc <= cyc + 1;

  // Records every forwarded beat as {id, data}; a timeout pulse without done is an error.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) beat_q.push_back({out_id, out_data});
      if (timeout_err && done == 4'd0) stray_to++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] r);
    for (int i = 1; i <= 4; i++) begin
      int c;
      c = (int'(last) + i) % 4;
      if (r[c]) return 2'(c);
    end
    return last;
  endfunction

  function automatic logic [255:0] lane_payload();
    logic [255:0] p;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 8; k++) p[64*r + 8*k +: 8] = 8'(8*r + k);
    return p;
  endfunction

  // One full transaction: grant, capture, start strobe, beats with gaps[] idle cycles before each.
  task automatic burst(input logic [3:0] reqv, input logic [255:0] pay, input logic [1:0] exp_id,
                       input logic [7:0] base, input bit stray);
    int         waited, nexp, end_cyc;
    bit         abort_exp;
    logic [7:0] expq [$];
    beat_q.delete();
    req = reqv;
    req_data = pay;
    waited = 0;
    do begin tick(); waited++; end while (ack == 4'd0 && waited < 20);
    check("ack_onehot", 64'(ack), 64'(4'b0001 << exp_id));
    for (int k = 0; k < 8; k++)
      check("a_lane", 64'(a_arr[k]), 64'(pay[{exp_id, 3'(k), 3'b000} +: 8]));
    req = 4'd0;
    if (stray) begin outen = 1'b1; dout = 8'hEE; end
    tick();
    check("begin_wr", 64'(begin_wr), 64'd1);
    check("ack_cleared", 64'(ack), 64'd0);
    outen = 1'b0;
    abort_exp = 1'b0;
    nexp = 0;
    for (int j = 0; j < BEATS; j++) begin
      if (gaps[j] >= TIMEOUT) begin
        repeat (TIMEOUT) tick();
        abort_exp = 1'b1;
        break;
      end
      repeat (gaps[j]) tick();
      outen = 1'b1;
      dout = base + 8'(j);
      expq.push_back(base + 8'(j));
      tick();
      outen = 1'b0;
      nexp++;
    end
    end_cyc = cyc;
    check("busy_in_burst", 64'(busy), 64'd1);
    check("no_early_done", 64'(done), 64'd0);
    waited = 0;
    do begin tick(); waited++; end while (done == 4'd0 && waited < 10);
    check("done_onehot", 64'(done), 64'(4'b0001 << exp_id));
    check("done_latency", 64'(cyc - end_cyc), 64'd1);
    check("timeout_err", 64'(timeout_err), 64'(abort_exp));
    check("beat_count", 64'(beat_q.size()), 64'(nexp));
    for (int j = 0; j < nexp && j < beat_q.size(); j++)
      check("beat_data_id", 64'(beat_q[j]), 64'({exp_id, expq[j]}));
    tick();
    check("busy_idle", 64'(busy), 64'd0);
    model_last = exp_id;
  endtask

  typedef struct {
    logic [3:0] r;
    logic [1:0] id;
  } vec_t;
  vec_t tbl [10];

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got timeout expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [255:0] pay;
    logic [3:0]   rv;
    rst_n = 1'b0; req = 4'd0; req_data = '0; dout = 8'd0; outen = 1'b0;
    model_last = 2'd3;
    foreach (gaps[j]) gaps[j] = 0;
    tbl[0] = '{4'b0001, 2'd0};
    tbl[1] = '{4'b1111, 2'd1};
    tbl[2] = '{4'b1111, 2'd2};
    tbl[3] = '{4'b1111, 2'd3};
    tbl[4] = '{4'b1111, 2'd0};
    tbl[5] = '{4'b1010, 2'd1};
    tbl[6] = '{4'b1010, 2'd3};
    tbl[7] = '{4'b0100, 2'd2};
    tbl[8] = '{4'b1001, 2'd3};
    tbl[9] = '{4'b0110, 2'd1};

    repeat (3) tick();
    check("reset_outputs", 64'({ack, done, begin_wr, out_data, out_valid, out_id, timeout_err, busy}), 64'd0);
    check("reset_lanes", {a_arr[0], a_arr[1], a_arr[2], a_arr[3], a_arr[4], a_arr[5], a_arr[6], a_arr[7]}, 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 10; i++)
      burst(tbl[i].r, lane_payload(), tbl[i].id, 8'h10, 1'b0);

    // Abort after three beats.
    foreach (gaps[j]) gaps[j] = 0;
    gaps[3] = TIMEOUT;
    burst(4'b0100, lane_payload(), 2'd2, 8'h30, 1'b0);

    // Final beat lands on the watchdog's last cycle, and a mid-burst beat does too.
    foreach (gaps[j]) gaps[j] = 0;
    gaps[2] = TIMEOUT - 1;
    gaps[7] = TIMEOUT - 1;
    burst(4'b0010, lane_payload(), 2'd1, 8'h40, 1'b0);

    // Stray outen in IDLE, then one during START of the next burst.
    foreach (gaps[j]) gaps[j] = 0;
    beat_q.delete();
    for (int p = 0; p < 5; p++) begin
      outen = p[0] ? 1'b0 : 1'b1;
      dout = 8'hA0 + 8'(p);
      tick();
    end
    outen = 1'b0;
    tick();
    check("stray_idle_beats", 64'(beat_q.size()), 64'd0);
    check("stray_idle_busy", 64'(busy), 64'd0);
    burst(4'b0001, lane_payload(), rr_pick(model_last, 4'b0001), 8'h50, 1'b1);

    // Reset in the middle of a stream.
    req = 4'b0001;
    req_data = lane_payload();
    for (int w = 0; w < 20 && ack == 4'd0; w++) tick();
    check("rst_seq_ack", 64'(ack), 64'(4'b0001 << rr_pick(model_last, 4'b0001)));
    req = 4'd0;
    tick();
    for (int j = 0; j < 4; j++) begin
      outen = 1'b1; dout = 8'h60 + 8'(j);
      tick();
    end
    outen = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_outputs", 64'({ack, done, begin_wr, out_data, out_valid, out_id, timeout_err, busy}), 64'd0);
    check("midrst_lanes", {a_arr[0], a_arr[1], a_arr[2], a_arr[3], a_arr[4], a_arr[5], a_arr[6], a_arr[7]}, 64'd0);
    #1 rst_n = 1'b1;
    model_last = 2'd3;
    beat_q.delete();
    for (int j = 0; j < 4; j++) begin
      outen = 1'b1; dout = 8'h70;
      tick();
      check("midrst_no_done", 64'(done), 64'd0);
    end
    outen = 1'b0;
    tick();
    check("midrst_no_beats", 64'(beat_q.size()), 64'd0);
    burst(4'b1000, lane_payload(), 2'd3, 8'h80, 1'b0);
    burst(4'b1001, lane_payload(), 2'd0, 8'h90, 1'b0);

    // Randomized bursts against the round-robin model.
    for (int it = 0; it < 25; it++) begin
      rv = 4'($urandom_range(1, 15));
      for (int w = 0; w < 8; w++) pay[32*w +: 32] = $urandom;
      foreach (gaps[j]) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 70)      gaps[j] = 0;
        else if (r < 90) gaps[j] = $urandom_range(1, 4);
        else if (r < 96) gaps[j] = TIMEOUT - 1;
        else             gaps[j] = TIMEOUT;
      end
      burst(rv, pay, rr_pick(model_last, rv), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    check("timeout_without_done", 64'(stray_to), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
